hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It drives the `stall` and `IF_ID_flush` inputs of the IF/ID register, the matching PC hold, and the ID/EX bubble insertion. It resolves load-use hazards, taken-branch squashes and the multi-cycle multiply/divide unit (MDU) interlock. It sits beside the ID stage and takes register and opcode summaries from ID and EX.

## Interface
Parameters:
- `MUL_CYCLES`, 4: busy cycles of a multiply; must be ≥1.
- `DIV_CYCLES`, 32: busy cycles of a divide; must be ≥1.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `ID_rs`, in, 5: rs field of the instruction in ID.
- `ID_rt`, in, 5: rt field of the instruction in ID.
- `ID_uses_rs`, in, 1: the ID instruction reads rs.
- `ID_uses_rt`, in, 1: the ID instruction reads rt.
- `ID_branch_taken`, in, 1: a branch or jump resolved taken in ID.
- `ID_mdu_use`, in, 1: the ID instruction is mfhi, mflo, mthi, mtlo, mult(u) or div(u).
- `EX_mem_read`, in, 1: the EX instruction is a load.
- `EX_rd`, in, 5: destination register of the EX instruction.
- `EX_mdu_start`, in, 1: a mult or div is in EX this cycle.
- `EX_mdu_div`, in, 1: qualifies `EX_mdu_start`; 1 = divide, 0 = multiply.
- `PC_stall`, out, 1: hold the PC.
- `stall`, out, 1: hold the IF/ID register.
- `IF_ID_flush`, out, 1: zero the IF/ID register.
- `ID_EX_flush`, out, 1: insert a bubble into ID/EX.
- `mdu_busy`, out, 1: the MDU is computing; HI/LO are not yet valid.

## Operation
- Load-use hazard (`lu`) = `EX_mem_read` & `EX_rd`≠0 & ((`ID_uses_rs` & `ID_rs`==`EX_rd`) | (`ID_uses_rt` & `ID_rt`==`EX_rd`)).
- MDU hazard (`mh`) = `mdu_busy` & `ID_mdu_use`.
- `hz` = `lu` | `mh`.
- When `hz` is 1: `PC_stall`, `stall` and `ID_EX_flush` are all 1, and `IF_ID_flush` is 0.
- When `hz` is 0: `IF_ID_flush` = `ID_branch_taken`, and the other three stall/flush outputs are 0.
- A branch whose operands are stalled is not trusted; a stall therefore suppresses the squash.
- MDU FSM states:
  - IDLE: `mdu_busy`=0.
  - BUSY: `mdu_busy`=1.
- Down-counter `cnt` has width $clog2(max(MUL_CYCLES,DIV_CYCLES)+1).
- IDLE to BUSY: on `EX_mdu_start`. Load `cnt` with `DIV_CYCLES`-1 if `EX_mdu_div`, otherwise `MUL_CYCLES`-1.
- BUSY with `cnt`≠0: decrement `cnt`.
- BUSY with `cnt`==0: go to IDLE.
- `EX_mdu_start` while in BUSY is ignored. It cannot occur legally, because `mh` stalls every MDU op in ID. The bench asserts that it never happens.
- All outputs are combinational from inputs, FSM state and `cnt`. There are no registered outputs.

## Timing
- Reset: on a `rst`-high edge, the FSM goes to IDLE and `cnt` to 0. From the following cycle `mdu_busy`=0.
- While `rst` is high, all outputs are forced to 0.
- Reset during BUSY aborts the operation. There is no carry-over.
- Load-use stall lasts exactly one cycle. The next cycle the load is in MEM, `EX_mem_read` normally drops, and forwarding covers the dependency.
- MDU latency: a start sampled at edge t gives `mdu_busy`=1 for exactly N cycles after edge t (N = `MUL_CYCLES` or `DIV_CYCLES`), then 0.
- A dependent `ID_mdu_use` instruction is released in the first cycle in which `mdu_busy`=0.
- N=1: a single busy cycle, entered with `cnt`=0.
- Simultaneous `lu` and `ID_branch_taken`: stall wins and there is no flush. The branch re-resolves on the next cycle.
- Simultaneous `lu` and `mh`: identical outputs; a single bubble per stalled cycle.
- `EX_rd`==0 never causes a stall.

## Structure
- `hazard_ctrl_pkg` holds:
  - the `mdu_state_t` enum {IDLE, BUSY};
  - the default cycle constants `MUL_CYCLES_DEF`=4 and `DIV_CYCLES_DEF`=32.
- Sub-module `mdu_timer` owns the FSM and `cnt`. Its ports are clk, rst, start, div and busy.
- The hazard comparators and the output priority logic sit in the top level.

## Test plan
- Load-use on rs: `EX_mem_read`=1, `EX_rd`=5, `ID_uses_rs`=1, `ID_rs`=5 → `stall`, `PC_stall` and `ID_EX_flush` are 1 for one cycle; `IF_ID_flush`=0.
- Load into $0: `EX_rd`=0, `ID_rs`=0 → no stall. Branch squash: `ID_branch_taken`=1 with no hazard → `IF_ID_flush`=1, all other stall/flush outputs 0.
- Branch plus load-use in the same cycle → `stall`=1 and `IF_ID_flush`=0. Next cycle, with the hazard gone and `ID_branch_taken` still 1 → `IF_ID_flush`=1.
- Divide timing (`DIV_CYCLES`=32): pulse `EX_mdu_start`=1 with `EX_mdu_div`=1 → `mdu_busy` high for exactly 32 cycles. Hold `ID_mdu_use`=1 → `stall` high for those 32 cycles and low in cycle 33.
- Multiply reset abort (`MUL_CYCLES`=4): start a multiply, assert `rst` in busy cycle 2 → `mdu_busy`=0 from the cycle after the reset edge. A fresh start then yields exactly 4 busy cycles.
- Edge case `MUL_CYCLES`=1: start a multiply → exactly 1 busy cycle. Random stimulus: `EX_mdu_start` never coincides with `mdu_busy`; this is asserted.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types and constants for the hazard controller
package hazard_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_t;

  localparam int MUL_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF = 32;

  // Counter width wide enough to hold the larger of the two busy lengths
  function automatic int mdu_cnt_width(input int mul_cycles, input int div_cycles);
    return $clog2(((mul_cycles > div_cycles) ? mul_cycles : div_cycles) + 1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_timer.sv
// rtl/hazard_ctrl_mdu_timer.sv - multiply/divide busy timer (IDLE/BUSY FSM with down-counter)
module mdu_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic div,
  output logic busy
);

  localparam int CW = mdu_cnt_width(MUL_CYCLES, DIV_CYCLES);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  mdu_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // State and counter registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a start in IDLE loads N-1 so BUSY lasts exactly N cycles; starts in BUSY are ignored
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          cnt_d   = div ? DIV_LOAD : MUL_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q == BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use, branch squash and MDU interlock control for the 5-stage pipeline
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_uses_rs,
  input  logic       ID_uses_rt,
  input  logic       ID_branch_taken,
  input  logic       ID_mdu_use,
  input  logic       EX_mem_read,
  input  logic [4:0] EX_rd,
  input  logic       EX_mdu_start,
  input  logic       EX_mdu_div,
  output logic       PC_stall,
  output logic       stall,
  output logic       IF_ID_flush,
  output logic       ID_EX_flush,
  output logic       mdu_busy
);

  logic timer_busy;
  logic rs_match;
  logic rt_match;
  logic lu;
  logic mh;
  logic hz;

  mdu_timer #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) u_mdu_timer (
    .clk  (clk),
    .rst  (rst),
    .start(EX_mdu_start),
    .div  (EX_mdu_div),
    .busy (timer_busy)
  );

  // A load into $0 produces nothing to wait for, so it never matches
  assign rs_match = ID_uses_rs && (ID_rs == EX_rd);
  assign rt_match = ID_uses_rt && (ID_rt == EX_rd);
  assign lu       = EX_mem_read && (EX_rd != 5'd0) && (rs_match || rt_match);
  assign mh       = timer_busy && ID_mdu_use;
  assign hz       = lu || mh;

  // Output priority: a stall freezes IF/ID and suppresses the squash of an untrusted branch
  always_comb begin
    PC_stall    = 1'b0;
    stall       = 1'b0;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    mdu_busy    = 1'b0;
    if (!rst) begin
      mdu_busy = timer_busy;
      if (hz) begin
        PC_stall    = 1'b1;
        stall       = 1'b1;
        ID_EX_flush = 1'b1;
      end else begin
        IF_ID_flush = ID_branch_taken;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl against a behavioural model
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] ID_rs, ID_rt, EX_rd;
  logic       ID_uses_rs, ID_uses_rt, ID_branch_taken, ID_mdu_use, EX_mem_read;
  logic [1:0] start, div;
  logic [1:0] pc_stall, stall, if_flush, ex_flush, busy;

  int checks = 0;
  int errors = 0;

  // Model state: remaining busy cycles per instance
  int rem[2] = '{0, 0};
  int mul_n[2] = '{4, 1};
  int div_n[2] = '{32, 3};

  int nb, ns;

  hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32)) u_dut_a (
    .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
    .ID_branch_taken(ID_branch_taken), .ID_mdu_use(ID_mdu_use),
    .EX_mem_read(EX_mem_read), .EX_rd(EX_rd),
    .EX_mdu_start(start[0]), .EX_mdu_div(div[0]),
    .PC_stall(pc_stall[0]), .stall(stall[0]), .IF_ID_flush(if_flush[0]),
    .ID_EX_flush(ex_flush[0]), .mdu_busy(busy[0])
  );

  hazard_ctrl #(.MUL_CYCLES(1), .DIV_CYCLES(3)) u_dut_b (
    .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
    .ID_branch_taken(ID_branch_taken), .ID_mdu_use(ID_mdu_use),
    .EX_mem_read(EX_mem_read), .EX_rd(EX_rd),
    .EX_mdu_start(start[1]), .EX_mdu_div(div[1]),
    .PC_stall(pc_stall[1]), .stall(stall[1]), .IF_ID_flush(if_flush[1]),
    .ID_EX_flush(ex_flush[1]), .mdu_busy(busy[1])
  );

  task automatic check(input string name, input int k, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0b expected %0b at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: a start sampled in an idle cycle makes the unit busy for N following cycles
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) rem[k] = 0;
      else if (rem[k] > 0) rem[k] = rem[k] - 1;
      else if (start[k]) rem[k] = div[k] ? div_n[k] : mul_n[k];
    end
  end

  // Per-cycle comparison of every output against the rules
  always @(negedge clk) begin
    logic lu, mb, hz;
    lu = EX_mem_read && (EX_rd != 0) &&
         ((ID_uses_rs && ID_rs == EX_rd) || (ID_uses_rt && ID_rt == EX_rd));
    for (int k = 0; k < 2; k++) begin
      mb = !rst && (rem[k] > 0);
      hz = lu || (mb && ID_mdu_use);
      check("m_busy", k, busy[k], mb);
      check("m_pc_stall", k, pc_stall[k], !rst && hz);
      check("m_stall", k, stall[k], !rst && hz);
      check("m_ex_flush", k, ex_flush[k], !rst && hz);
      check("m_if_flush", k, if_flush[k], !rst && !hz && ID_branch_taken);
      check("start_not_busy", k, start[k] && busy[k], 1'b0);
    end
  end

  initial begin
    rst = 1'b1;
    ID_rs = '0; ID_rt = '0; EX_rd = '0;
    ID_uses_rs = 0; ID_uses_rt = 0; ID_branch_taken = 0; ID_mdu_use = 0; EX_mem_read = 0;
    start = '0; div = '0;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 0, busy[0], 1'b0);
    check("reset_stall", 0, stall[0], 1'b0);

    // Load-use on rs
    EX_mem_read = 1; EX_rd = 5'd5; ID_uses_rs = 1; ID_rs = 5'd5;
    @(negedge clk);
    check("lu_stall", 0, stall[0], 1'b1);
    check("lu_pc_stall", 0, pc_stall[0], 1'b1);
    check("lu_ex_flush", 0, ex_flush[0], 1'b1);
    check("lu_if_flush", 0, if_flush[0], 1'b0);
    step();
    EX_mem_read = 0;
    @(negedge clk);
    check("lu_released", 0, stall[0], 1'b0);

    // Load into $0
    EX_mem_read = 1; EX_rd = 5'd0; ID_rs = 5'd0;
    @(negedge clk);
    check("rd0_no_stall", 0, stall[0], 1'b0);

    // Branch squash with no hazard
    EX_mem_read = 0; ID_branch_taken = 1;
    @(negedge clk);
    check("br_flush", 0, if_flush[0], 1'b1);
    check("br_no_stall", 0, stall[0], 1'b0);

    // Branch plus load-use: stall wins, then squash
    EX_mem_read = 1; EX_rd = 5'd7; ID_rs = 5'd7;
    @(negedge clk);
    check("br_lu_stall", 0, stall[0], 1'b1);
    check("br_lu_no_flush", 0, if_flush[0], 1'b0);
    step();
    EX_mem_read = 0;
    @(negedge clk);
    check("br_after_flush", 0, if_flush[0], 1'b1);
    step();
    ID_branch_taken = 0; ID_uses_rs = 0;

    // Divide on instance A with a dependent MDU instruction held in ID
    start[0] = 1; div[0] = 1; ID_mdu_use = 1;
    step();
    start[0] = 0; div[0] = 0;
    nb = 0; ns = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy[0]) nb++;
      if (stall[0]) ns++;
      if (i == 31) check("div_last_busy", 0, stall[0], 1'b1);
      if (i == 32) check("div_released", 0, stall[0], 1'b0);
      step();
    end
    check_int("div_busy_cycles", nb, 32);
    check_int("div_stall_cycles", ns, 32);
    ID_mdu_use = 0;

    // Multiply aborted by reset in busy cycle 2, then a fresh multiply
    start[0] = 1;
    step();
    start[0] = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    check("abort_busy", 0, busy[0], 1'b0);
    start[0] = 1;
    step();
    start[0] = 0;
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy[0]) nb++;
      step();
    end
    check_int("mul_busy_cycles", nb, 4);

    // Single-cycle multiply on instance B
    start[1] = 1;
    step();
    start[1] = 0;
    nb = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy[1]) nb++;
      step();
    end
    check_int("mul1_busy_cycles", nb, 1);

    // Random traffic; starts only issued while the model says the unit is idle
    for (int c = 0; c < 3000; c++) begin
      EX_mem_read     = 1'($urandom_range(0, 1));
      EX_rd           = 5'($urandom_range(0, 3));
      ID_rs           = 5'($urandom_range(0, 3));
      ID_rt           = 5'($urandom_range(0, 3));
      ID_uses_rs      = 1'($urandom_range(0, 1));
      ID_uses_rt      = 1'($urandom_range(0, 1));
      ID_branch_taken = 1'($urandom_range(0, 1));
      ID_mdu_use      = 1'($urandom_range(0, 1));
      rst             = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < 2; k++) begin
        start[k] = (rem[k] == 0) && ($urandom_range(0, 5) == 0);
        div[k]   = 1'($urandom_range(0, 1));
      end
      step();
    end

    start = '0;
    rst = 0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
